eth_mac_pause_tx_mux: RTL

//  Sits in the tx_clk domain between the TX async FIFO output and the 1G MAC TX input (8-bit AXIS).

---
 rtl/eth_mac_pause_tx_mux.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/eth_mac_pause_tx_mux.sv
// TX-side AXIS mux between the TX FIFO and the 1G MAC: forwards FIFO frames untouched and
// inserts 60-byte 802.3x PAUSE frames (XOFF / XON / periodic XOFF refresh) between frames.
module eth_mac_pause_tx_mux #(
  parameter int REFRESH_PERIOD = 32768,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] cfg_src_mac,
  input  logic        cfg_pause_enable,
  input  logic        pause_req,
  input  logic [15:0] pause_quanta,
  output logic        status_pause_sent
);

  localparam logic [5:0] LAST_IDX   = 6'd59;
  localparam bit         REFRESH_EN = (REFRESH_PERIOD != 0);
  localparam logic [CNT_WIDTH-1:0] REFRESH_LAST =
    REFRESH_EN ? CNT_WIDTH'(REFRESH_PERIOD - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 pending_reg, pending_next;
  logic                 pause_req_d_reg;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [5:0]           byte_idx_reg, byte_idx_next;
  logic [15:0]          quanta_reg, quanta_next;
  logic                 status_reg, status_next;

  logic                 pass_through;
  logic                 s_fire;
  logic                 m_fire;
  logic                 pause_last;
  logic                 pause_done;
  logic                 req_edge;
  logic                 refresh_hit;
  logic [7:0]           frame_bytes [0:63];

  // Byte image of the PAUSE frame; entries past the last byte are never selected.
  function automatic logic [7:0] pause_byte(input int idx, input logic [47:0] mac,
                                            input logic [15:0] q);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      0:  b = 8'h01;
      1:  b = 8'h80;
      2:  b = 8'hC2;
      3:  b = 8'h00;
      4:  b = 8'h00;
      5:  b = 8'h01;
      6:  b = mac[47:40];
      7:  b = mac[39:32];
      8:  b = mac[31:24];
      9:  b = mac[23:16];
      10: b = mac[15:8];
      11: b = mac[7:0];
      12: b = 8'h88;
      13: b = 8'h08;
      14: b = 8'h00;
      15: b = 8'h01;
      16: b = q[15:8];
      17: b = q[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_pause_rom
      assign frame_bytes[gi] = pause_byte(gi, cfg_src_mac, quanta_reg);
    end
  endgenerate

  assign pass_through = !tx_rst &&
                        ((state_reg == PASS) || (state_reg == IDLE && !pending_reg));
  assign pause_last   = (byte_idx_reg == LAST_IDX);
  assign s_fire       = s_axis_tvalid && s_axis_tready;
  assign m_fire       = m_axis_tvalid && m_axis_tready;
  assign pause_done   = (state_reg == PAUSE) && m_fire && pause_last;
  assign req_edge     = pause_req ^ pause_req_d_reg;
  assign status_pause_sent = status_reg;

  // Output mux: reset forces everything low so a frame in flight is cut immediately.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    if (pass_through) begin
      s_axis_tready = m_axis_tready;
      m_axis_tvalid = s_axis_tvalid;
      m_axis_tdata  = s_axis_tdata;
      m_axis_tlast  = s_axis_tlast;
      m_axis_tuser  = s_axis_tuser;
    end else if (!tx_rst && state_reg == PAUSE) begin
      m_axis_tvalid = 1'b1;
      m_axis_tdata  = frame_bytes[byte_idx_reg];
      m_axis_tlast  = pause_last;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pending_next  = pending_reg;
    cnt_next      = cnt_reg;
    byte_idx_next = byte_idx_reg;
    quanta_next   = quanta_reg;
    status_next   = 1'b0;
    refresh_hit   = 1'b0;

    // Refresh timer runs only while XOFF is requested and is frozen during a pause frame.
    if (!REFRESH_EN || !pause_req || pause_done) begin
      cnt_next = '0;
    end else if (state_reg != PAUSE) begin
      if (cnt_reg == REFRESH_LAST) begin
        cnt_next    = '0;
        refresh_hit = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next    = PAUSE;
          byte_idx_next = 6'd0;
          quanta_next   = pause_req ? pause_quanta : 16'h0000;
        end else if (s_fire && !s_axis_tlast) begin
          state_next = PASS;
        end
      end
      PASS: begin
        if (s_fire && s_axis_tlast) begin
          state_next = IDLE;
        end
      end
      PAUSE: begin
        if (m_fire) begin
          if (pause_last) begin
            state_next  = IDLE;
            status_next = 1'b1;
          end else begin
            byte_idx_next = byte_idx_reg + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The level sampled at frame start already covers an edge seen in that same cycle.
    if (cfg_pause_enable && (req_edge || refresh_hit)) begin
      pending_next = 1'b1;
    end
    if ((state_reg == IDLE && pending_reg) || !cfg_pause_enable) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_reg       <= IDLE;
      pending_reg     <= 1'b0;
      pause_req_d_reg <= 1'b0;
      cnt_reg         <= '0;
      byte_idx_reg    <= 6'd0;
      quanta_reg      <= 16'h0000;
      status_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pending_reg     <= pending_next;
      pause_req_d_reg <= pause_req;
      cnt_reg         <= cnt_next;
      byte_idx_reg    <= byte_idx_next;
      quanta_reg      <= quanta_next;
      status_reg      <= status_next;
    end
  end

endmodule
